// File: rtl/lfsr_checker.sv
// lfsr_checker: receive-side checker for an N-bit parallel LFSR stream.
// It hunts for a nonzero seed and verifies the recurrence
// next = {^cur[N-2:0], cur[N-1:1]} for LOCK_CNT consecutive words before it locks.
// Once locked, it free-runs its own reference and flags and counts words that break the recurrence.
// Optional build macro LFSR_CHK_BITERR_EN: err_count accumulates bit errors
// (popcount of in_data ^ expected) instead of word errors.
module lfsr_checker #(
    parameter int N           = 5,
    parameter int LOCK_CNT    = 4,
    parameter int UNLOCK_ERRS = 3,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             in_valid,
    input  logic [N-1:0]     in_data,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic             lock_lost,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [1:0] HUNT   = 2'd0;
    localparam logic [1:0] VERIFY = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    localparam int MC_W  = $clog2(LOCK_CNT + 1);
    localparam int MS_W  = $clog2(UNLOCK_ERRS + 1);
    localparam int POP_W = $clog2(N + 1);
    localparam int SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;

    localparam logic [MC_W-1:0]  MATCH_LAST = MC_W'(LOCK_CNT - 1);
    localparam logic [MS_W-1:0]  MISS_LAST  = MS_W'(UNLOCK_ERRS - 1);
    localparam logic [SUM_W-1:0] CNT_MAX    = {{(SUM_W - CNT_W){1'b0}}, {CNT_W{1'b1}}};

    logic [1:0]       state;
    logic [N-1:0]     prev;
    logic [MC_W-1:0]  match_cnt;
    logic [MS_W-1:0]  miss_cnt;

    logic [N-1:0]     exp_word;
    logic             match;
    logic [SUM_W-1:0] inc;
    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] cnt_next;

    // Expected word from the reference, and the saturated error-count candidate
    always_comb begin
        exp_word = {^prev[N-2:0], prev[N-1:1]};
        match    = (in_data == exp_word);
`ifdef LFSR_CHK_BITERR_EN
        inc = '0;
        for (int unsigned i = 0; i < N; i++) begin
            inc = inc + SUM_W'(in_data[i] ^ exp_word[i]);
        end
`else
        inc = SUM_W'(1);
`endif
        sum      = SUM_W'(err_count) + inc;
        cnt_next = (sum > CNT_MAX) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end

    // Hunt / verify / locked state machine with registered outputs
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state     <= HUNT;
            prev      <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            lock_lost <= 1'b0;
            err_count <= '0;
        end else begin
            err_pulse <= 1'b0;
            lock_lost <= 1'b0;
            if (clear) begin
                err_count <= '0;
            end
            if (in_valid) begin
                case (state)
                    HUNT: begin
                        if (in_data != '0) begin
                            prev      <= in_data;
                            match_cnt <= '0;
                            state     <= VERIFY;
                        end
                    end
                    VERIFY: begin
                        prev <= in_data;
                        if (in_data == '0) begin
                            state <= HUNT;
                        end else if (match) begin
                            if (match_cnt == MATCH_LAST) begin
                                state     <= LOCKED;
                                locked    <= 1'b1;
                                miss_cnt  <= '0;
                                match_cnt <= '0;
                            end else begin
                                match_cnt <= match_cnt + 1'b1;
                            end
                        end else begin
                            match_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        // Flywheel: the reference advances on its own, line errors never reseed it
                        prev <= exp_word;
                        if (match) begin
                            miss_cnt <= '0;
                        end else begin
                            err_pulse <= 1'b1;
                            if (!clear) begin
                                err_count <= cnt_next;
                            end
                            if (miss_cnt == MISS_LAST) begin
                                state     <= HUNT;
                                locked    <= 1'b0;
                                lock_lost <= 1'b1;
                                miss_cnt  <= '0;
                            end else begin
                                miss_cnt <= miss_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed testbench for lfsr_checker (N=5, LOCK_CNT=4, UNLOCK_ERRS=3).
// A second instance with CNT_W=2 shares the stimulus to exercise saturation.
module tb_lfsr_checker;

`ifdef LFSR_CHK_BITERR_EN
    localparam bit BITERR = 1'b1;
`else
    localparam bit BITERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        areset = 1'b0;
    logic        in_valid = 1'b0;
    logic [4:0]  in_data = '0;
    logic        clear = 1'b0;
    logic        locked, err_pulse, lock_lost;
    logic [15:0] err_count;
    logic        locked_s, err_pulse_s, lock_lost_s;
    logic [1:0]  err_count_s;

    int n_checks = 0;
    int n_errors = 0;

    lfsr_checker #(.N(5), .LOCK_CNT(4), .UNLOCK_ERRS(3), .CNT_W(16)) dut (
        .clk(clk), .areset(areset), .in_valid(in_valid), .in_data(in_data), .clear(clear),
        .locked(locked), .err_pulse(err_pulse), .lock_lost(lock_lost), .err_count(err_count)
    );

    lfsr_checker #(.N(5), .LOCK_CNT(4), .UNLOCK_ERRS(3), .CNT_W(2)) dut_sat (
        .clk(clk), .areset(areset), .in_valid(in_valid), .in_data(in_data), .clear(clear),
        .locked(locked_s), .err_pulse(err_pulse_s), .lock_lost(lock_lost_s), .err_count(err_count_s)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // One clock cycle with the given inputs; returns 1 time unit after the edge
    task automatic cyc(input logic v, input logic [4:0] d, input logic c);
        in_valid = v;
        in_data  = d;
        clear    = c;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic send(input logic [4:0] d);
        cyc(1'b1, d, 1'b0);
    endtask

    task automatic do_reset();
        #2 areset = 1'b0;
        #10 areset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #7 areset = 1'b1;
        @(posedge clk);
        #1;
        check("reset_locked", int'(locked), 0);
        check("reset_pulse", int'(err_pulse), 0);
        check("reset_lost", int'(lock_lost), 0);
        check("reset_count", int'(err_count), 0);

        // Acquire lock on the reference sequence
        send(5'h01); send(5'h10); send(5'h08); send(5'h14);
        check("lock_not_yet", int'(locked), 0);
        send(5'h1A);
        check("lock_after_5", int'(locked), 1);
        check("lock_count0", int'(err_count), 0);
        check("lock_no_pulse", int'(err_pulse), 0);

        // Single error, then flywheel continues
        send(5'h0C);
        check("err1_pulse", int'(err_pulse), 1);
        check("err1_count", int'(err_count), 1);
        check("err1_locked", int'(locked), 1);
        send(5'h16);
        check("fly_pulse", int'(err_pulse), 0);
        check("fly_count", int'(err_count), 1);
        check("fly_locked", int'(locked), 1);
        send(5'h0B);
        // Two misses, good, two misses: miss counter must reset on the good word
        send(5'h14); send(5'h0B); send(5'h05); send(5'h03); send(5'h10);
        check("miss_reset_locked", int'(locked), 1);
        check("five_errs_count", int'(err_count), 5);
        check("sat_count", int'(err_count_s), 3);
        cyc(1'b0, 5'h1F, 1'b0);
        check("idle_pulse", int'(err_pulse), 0);
        check("idle_count", int'(err_count), 5);
        check("idle_locked", int'(locked), 1);
        send(5'h18);
        cyc(1'b1, 5'h1D, 1'b1);
        check("clear_pulse", int'(err_pulse), 1);
        check("clear_count", int'(err_count), 0);
        check("clear_sat_count", int'(err_count_s), 0);
        check("clear_locked", int'(locked), 1);
        send(5'h0E);

        // Three consecutive corrupted words drop lock
        send(5'h16);
        check("ul1_count", int'(err_count), 1);
        send(5'h1A);
        check("ul2_lost", int'(lock_lost), 0);
        check("ul2_locked", int'(locked), 1);
        send(5'h1C);
        check("ul3_count", int'(err_count), 3);
        check("ul3_lost", int'(lock_lost), 1);
        check("ul3_locked", int'(locked), 0);
        send(5'h00);
        check("zero_lost_pulse", int'(lock_lost), 0);
        send(5'h00); send(5'h00);
        check("zero_hunt_locked", int'(locked), 0);
        check("zero_hunt_count", int'(err_count), 3);

        // Relock with idle gaps; err_count holds across relock
        send(5'h01); cyc(1'b0, 5'h00, 1'b0);
        send(5'h10); cyc(1'b0, 5'h00, 1'b0);
        send(5'h08); cyc(1'b0, 5'h00, 1'b0);
        send(5'h14); cyc(1'b0, 5'h00, 1'b0);
        check("gap_not_yet", int'(locked), 0);
        send(5'h1A);
        check("gap_locked", int'(locked), 1);
        cyc(1'b0, 5'h00, 1'b0);
        check("gap_idle_locked", int'(locked), 1);
        check("gap_count_held", int'(err_count), 3);

        // 12 instead of 0D: 5 bit errors
        send(5'h12);
        check("multi_bit_pulse", int'(err_pulse), 1);
        check("multi_bit_count", int'(err_count), BITERR ? 8 : 4);
        check("multi_bit_sat", int'(err_count_s), 3);

        // Asynchronous reset between clock edges
        #2 areset = 1'b0;
        #1;
        check("async_locked", int'(locked), 0);
        check("async_count", int'(err_count), 0);
        #4 areset = 1'b1;
        @(posedge clk);
        #1;

        // Mismatch in VERIFY reseeds from the line
        send(5'h01); send(5'h10); send(5'h08);
        send(5'h05); send(5'h02); send(5'h11); send(5'h18);
        check("reseed_not_yet", int'(locked), 0);
        send(5'h1C);
        check("reseed_locked", int'(locked), 1);
        check("reseed_count", int'(err_count), 0);

        // Zero word in VERIFY returns to HUNT
        do_reset();
        send(5'h01); send(5'h10); send(5'h00);
        send(5'h08); send(5'h14); send(5'h1A); send(5'h0D);
        check("vzero_not_yet", int'(locked), 0);
        send(5'h16);
        check("vzero_locked", int'(locked), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
